// File: rtl/serial_mem_loader_pkg.sv
// Shared definitions for the serial program-memory loader.
//   state_e           : loader FSM states
//   SYNC_BYTE_DEF     : default frame start marker
//   FIELD_W           : width of the big-endian address / length header fields
//   BYTES_PER_WORD    : payload bytes packed into one memory word
//   WORD_W            : memory data width
//   consumes_byte()   : states in which the loader accepts a byte from the receiver
package serial_loader_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR_H,
        ADDR_L,
        LEN_H,
        LEN_L,
        DATA,
        WRITE,
        CSUM,
        DONE,
        ERR
    } state_e;

    localparam logic [7:0] SYNC_BYTE_DEF  = 8'hA5;
    localparam int         FIELD_W        = 16;
    localparam int         BYTES_PER_WORD = 4;
    localparam int         WORD_W         = 8 * BYTES_PER_WORD;
    localparam int         BCNT_W         = $clog2(BYTES_PER_WORD);

    // WRITE, DONE and ERR are the only states that cannot take a byte.
    function automatic logic consumes_byte(input state_e s);
        return (s != WRITE) && (s != DONE) && (s != ERR);
    endfunction

endpackage

// File: rtl/serial_mem_loader_if.sv
// Byte-stream input and memory write-port signals of the loader.
//   rx_data/rx_valid/rx_ready : byte stream from the serial receiver
//   mem_*                     : Avalon slave write port of the program memory
// master : loader side (consumes the stream, drives the memory port)
// slave  : environment side (receiver + memory)
interface serial_mem_loader_if
    import serial_loader_pkg::*;
#(
    parameter int ADDR_W = 12
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [WORD_W-1:0] mem_writedata;
    logic              mem_clken;

    modport master (
        input  rx_data, rx_valid,
        output rx_ready,
        output mem_address, mem_byteenable, mem_chipselect, mem_write,
        output mem_writedata, mem_clken
    );

    modport slave (
        output rx_data, rx_valid,
        input  rx_ready,
        input  mem_address, mem_byteenable, mem_chipselect, mem_write,
        input  mem_writedata, mem_clken
    );
endinterface

// File: rtl/serial_mem_loader_packer.sv
// byte_word_packer: packs payload bytes little-endian into a memory word and
// keeps the 8-bit modulo sum of every byte packed since the last clear.
//   clk, rst_n     : clock, async active-low reset
//   clear_i        : zero counter, word and sum (frame start)
//   byte_valid_i   : byte_i is a payload byte to pack this cycle
//   byte_i         : payload byte
//   word_o         : packed word (byte k lives in bits [8k+7:8k])
//   sum_o          : running checksum
//   word_ready_o   : this cycle's byte completes the word
module byte_word_packer
    import serial_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_i,
    output logic [WORD_W-1:0] word_o,
    output logic [7:0]        sum_o,
    output logic              word_ready_o
);
    logic [BCNT_W-1:0] cnt_q, cnt_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [7:0]        sum_q, sum_d;

    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        sum_d  = sum_q;
        if (clear_i) begin
            cnt_d  = '0;
            word_d = '0;
            sum_d  = '0;
        end else if (byte_valid_i) begin
            word_d[8*cnt_q +: 8] = byte_i;
            sum_d                = sum_q + byte_i;
            // counter wraps naturally back to byte 0 after the last lane
            cnt_d                = cnt_q + BCNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            word_q <= '0;
            sum_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
            sum_q  <= sum_d;
        end
    end

    assign word_o       = word_q;
    assign sum_o        = sum_q;
    assign word_ready_o = byte_valid_i && (cnt_q == BCNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/serial_mem_loader.sv
// serial_mem_loader: receives a framed byte stream
//   SYNC, ADDR_H, ADDR_L, LEN_H, LEN_L, LEN*4 payload bytes, CSUM
// and writes the payload words into the program memory, holding the CPU in
// reset while a frame is in progress.
//   clk, reset_n   : clock, async active-low reset
//   bus (master)   : byte stream in, memory write port out
//   cpu_reset_req  : high from SYNC accept until the frame ends
//   load_done      : one-cycle pulse after a frame with a matching checksum
//   load_error     : sticky error flag, cleared by the next accepted SYNC
module serial_mem_loader
    import serial_loader_pkg::*;
#(
    parameter int         ADDR_W    = 12,
    parameter int         DEPTH     = 2560,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
)(
    input  logic                clk,
    input  logic                reset_n,
    serial_mem_loader_if.master bus,
    output logic                cpu_reset_req,
    output logic                load_done,
    output logic                load_error
);
    localparam logic [FIELD_W:0] DEPTH_L = (FIELD_W + 1)'(DEPTH);

    state_e             state_q, state_d;
    logic               run_q;
    logic [7:0]         addr_h_q, addr_h_d;
    logic [7:0]         len_h_q, len_h_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [FIELD_W-1:0] rem_q, rem_d;
    logic               load_error_q, load_error_d;

    logic               rx_fire;
    logic [FIELD_W-1:0] addr16, len16;
    logic [FIELD_W:0]   end_addr;

    logic               pk_clear, pk_valid, pk_word_ready;
    logic [WORD_W-1:0]  pk_word;
    logic [7:0]         pk_sum;

    // run_q keeps rx_ready and mem_clken low while reset is asserted and
    // releases them on the first clock edge afterwards.
    assign bus.rx_ready = run_q && consumes_byte(state_q);
    assign rx_fire      = bus.rx_valid && bus.rx_ready;

    // Header fields assembled from the stored high byte and the byte on the bus,
    // so the checks resolve in the same cycle the low byte is accepted.
    assign addr16   = {addr_h_q, bus.rx_data};
    assign len16    = {len_h_q, bus.rx_data};
    assign end_addr = {{(FIELD_W + 1 - ADDR_W){1'b0}}, addr_q} + {1'b0, len16};

    assign pk_valid = rx_fire && (state_q == DATA);

    byte_word_packer u_packer (
        .clk          (clk),
        .rst_n        (reset_n),
        .clear_i      (pk_clear),
        .byte_valid_i (pk_valid),
        .byte_i       (bus.rx_data),
        .word_o       (pk_word),
        .sum_o        (pk_sum),
        .word_ready_o (pk_word_ready)
    );

    always_comb begin
        state_d      = state_q;
        addr_h_d     = addr_h_q;
        len_h_d      = len_h_q;
        addr_d       = addr_q;
        rem_d        = rem_q;
        load_error_d = load_error_q;
        pk_clear     = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_fire && (bus.rx_data == SYNC_BYTE)) begin
                    load_error_d = 1'b0;
                    pk_clear     = 1'b1;
                    state_d      = ADDR_H;
                end
            end
            ADDR_H: begin
                if (rx_fire) begin
                    addr_h_d = bus.rx_data;
                    state_d  = ADDR_L;
                end
            end
            ADDR_L: begin
                if (rx_fire) begin
                    if ((addr16 >> ADDR_W) != '0) begin
                        state_d = ERR;
                    end else begin
                        addr_d  = addr16[ADDR_W-1:0];
                        state_d = LEN_H;
                    end
                end
            end
            LEN_H: begin
                if (rx_fire) begin
                    len_h_d = bus.rx_data;
                    state_d = LEN_L;
                end
            end
            LEN_L: begin
                if (rx_fire) begin
                    rem_d = len16;
                    // Range check up front: once accepted, the address can
                    // never step past DEPTH-1, so no wrap handling is needed.
                    if (end_addr > DEPTH_L) begin
                        state_d = ERR;
                    end else if (len16 == '0) begin
                        state_d = CSUM;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (pk_word_ready) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                addr_d  = addr_q + ADDR_W'(1);
                rem_d   = rem_q - FIELD_W'(1);
                state_d = (rem_q > FIELD_W'(1)) ? DATA : CSUM;
            end
            CSUM: begin
                if (rx_fire) begin
                    state_d = (bus.rx_data == pk_sum) ? DONE : ERR;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_d == ERR) begin
            load_error_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q        <= 1'b0;
            addr_h_q     <= '0;
            len_h_q      <= '0;
            addr_q       <= '0;
            rem_q        <= '0;
            load_error_q <= 1'b0;
        end else begin
            run_q        <= 1'b1;
            addr_h_q     <= addr_h_d;
            len_h_q      <= len_h_d;
            addr_q       <= addr_d;
            rem_q        <= rem_d;
            load_error_q <= load_error_d;
        end
    end

    assign bus.mem_address    = addr_q;
    assign bus.mem_byteenable = 4'hF;
    assign bus.mem_chipselect = (state_q == WRITE);
    assign bus.mem_write      = (state_q == WRITE);
    assign bus.mem_writedata  = pk_word;
    assign bus.mem_clken      = run_q;

    assign cpu_reset_req = (state_q != IDLE) && (state_q != DONE) && (state_q != ERR);
    assign load_done     = (state_q == DONE);
    assign load_error    = load_error_q;

endmodule

// File: tb/tb_serial_mem_loader.sv
// Self-checking bench for serial_mem_loader: directed frame table, a mid-frame
// reset sequence, and random frames scored against a frame-level model.
module tb_serial_mem_loader;
    import serial_loader_pkg::*;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic cpu_reset_req, load_done, load_error;

    serial_mem_loader_if #(.ADDR_W(12)) bus();

    serial_mem_loader #(
        .ADDR_W    (12),
        .DEPTH     (2560),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .bus           (bus),
        .cpu_reset_req (cpu_reset_req),
        .load_done     (load_done),
        .load_error    (load_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] b;     // frame bytes, first byte in the top 8 bits
        int           n;     // number of bytes sent
        int           nw;    // expected writes
        logic [11:0]  a0;
        logic [31:0]  d0;
        logic [11:0]  a1;
        logic [31:0]  d1;
        bit           done;
        bit           err;
        int           stl;   // expected rx_ready stall cycles with rx_valid held high
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [43:0] got_q[$];
    logic [43:0] exp_q[$];
    logic [7:0]  tx_q[$];
    logic [7:0]  pay_q[$];
    int          done_cnt = 0;
    int          creq_cnt = 0;

    // Observe mid-cycle: writes, done pulse cycles, and CPU-hold cycles.
    always @(negedge clk) begin
        if (bus.mem_chipselect && bus.mem_write)
            got_q.push_back({bus.mem_address, bus.mem_writedata});
        if (load_done) done_cnt++;
        if (cpu_reset_req) creq_cnt++;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte transferred.
    task automatic send_byte(input logic [7:0] b, input int gap, output int stall);
        int n;
        n = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (!bus.rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        stall = n;
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL rx_timeout: byte %0h not accepted, required accept within 50 cycles", b);
            bus.rx_valid = 1'b0;
            return;
        end
        @(negedge clk);
        if (gap > 0) begin
            bus.rx_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic begin_frame();
        got_q.delete();
        done_cnt = 0;
        creq_cnt = 0;
    endtask

    task automatic send_frame(input int gap_max, output int stalls);
        int s;
        stalls = 0;
        foreach (tx_q[i]) begin
            send_byte(tx_q[i], (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0, s);
            stalls += s;
        end
        bus.rx_valid = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic check_result(input string tag, input bit exp_done, input bit exp_err);
        chk({tag, ".nwr"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s.wr%0d", tag, i), got_q[i], exp_q[i]);
        chk({tag, ".done_cycles"}, done_cnt, exp_done);
        chk({tag, ".load_error"}, load_error, exp_err);
        chk({tag, ".creq_end"}, cpu_reset_req, 1'b0);
        chk({tag, ".creq_seen"}, creq_cnt > 0, 1'b1);
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int stalls;
        tx_q.delete();
        exp_q.delete();
        for (int i = 0; i < v.n; i++) tx_q.push_back(v.b[127 - 8*i -: 8]);
        if (v.nw >= 1) exp_q.push_back({v.a0, v.d0});
        if (v.nw >= 2) exp_q.push_back({v.a1, v.d1});
        begin_frame();
        send_frame(0, stalls);
        check_result(tag, v.done, v.err);
        chk({tag, ".stalls"}, stalls, v.stl);
    endtask

    initial begin
        vec_t        tbl[7];
        int          stalls;
        int          s;
        logic [15:0] a;
        int          len, mode, sum, csum;
        bit          bad, hdr_err;
        logic [7:0]  nb;

        tbl[0] = '{b:128'hA5_00_10_00_02_11_22_33_44_55_66_77_88_64_00_00, n:14, nw:2,
                   a0:12'h010, d0:32'h44332211, a1:12'h011, d1:32'h88776655, done:1, err:0, stl:2};
        tbl[1] = '{b:128'hA5_00_10_00_02_11_22_33_44_55_66_77_88_65_00_00, n:14, nw:2,
                   a0:12'h010, d0:32'h44332211, a1:12'h011, d1:32'h88776655, done:0, err:1, stl:2};
        tbl[2] = '{b:128'hA5_09_FF_00_02_00_00_00_00_00_00_00_00_00_00_00, n:5, nw:0,
                   a0:12'h0, d0:32'h0, a1:12'h0, d1:32'h0, done:0, err:1, stl:0};
        tbl[3] = '{b:128'hA5_09_FE_00_02_01_02_03_04_05_06_07_08_24_00_00, n:14, nw:2,
                   a0:12'h9FE, d0:32'h04030201, a1:12'h9FF, d1:32'h08070605, done:1, err:0, stl:2};
        tbl[4] = '{b:128'hA5_00_00_00_00_00_00_00_00_00_00_00_00_00_00_00, n:6, nw:0,
                   a0:12'h0, d0:32'h0, a1:12'h0, d1:32'h0, done:1, err:0, stl:0};
        tbl[5] = '{b:128'h00_FF_A5_00_20_00_01_DE_AD_BE_EF_38_00_00_00_00, n:12, nw:1,
                   a0:12'h020, d0:32'hEFBEADDE, a1:12'h0, d1:32'h0, done:1, err:0, stl:1};
        // address 0x1000 exceeds 12 bits: error after ADDR_L, LEN bytes hit ERR then IDLE
        tbl[6] = '{b:128'hA5_10_00_00_00_00_00_00_00_00_00_00_00_00_00_00, n:5, nw:0,
                   a0:12'h0, d0:32'h0, a1:12'h0, d1:32'h0, done:0, err:1, stl:1};

        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst.rx_ready",   bus.rx_ready, 1'b0);
        chk("rst.mem_addr",   bus.mem_address, 12'h000);
        chk("rst.mem_be",     bus.mem_byteenable, 4'hF);
        chk("rst.mem_cs",     bus.mem_chipselect, 1'b0);
        chk("rst.mem_wr",     bus.mem_write, 1'b0);
        chk("rst.mem_wdata",  bus.mem_writedata, 32'h0);
        chk("rst.mem_clken",  bus.mem_clken, 1'b0);
        chk("rst.creq",       cpu_reset_req, 1'b0);
        chk("rst.done",       load_done, 1'b0);
        chk("rst.err",        load_error, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rel.rx_ready",  bus.rx_ready, 1'b1);
        chk("rel.mem_clken", bus.mem_clken, 1'b1);
        repeat (2) @(negedge clk);

        // Directed frame table, rx_valid held high throughout
        for (int i = 0; i < 7; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

        // Async reset in the middle of the second payload word
        begin_frame();
        tx_q.delete();
        tx_q = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        foreach (tx_q[i]) send_byte(tx_q[i], 0, s);
        chk("midrst.nwr_before", got_q.size(), 1);
        if (got_q.size() > 0) chk("midrst.wr0", got_q[0], {12'h010, 32'h44332211});
        chk("midrst.creq_before", cpu_reset_req, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst.rx_ready", bus.rx_ready, 1'b0);
        chk("midrst.mem_cs",   bus.mem_chipselect, 1'b0);
        chk("midrst.mem_wr",   bus.mem_write, 1'b0);
        chk("midrst.mem_addr", bus.mem_address, 12'h000);
        chk("midrst.wdata",    bus.mem_writedata, 32'h0);
        chk("midrst.clken",    bus.mem_clken, 1'b0);
        chk("midrst.creq",     cpu_reset_req, 1'b0);
        chk("midrst.err",      load_error, 1'b0);
        bus.rx_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        run_vec("postrst", tbl[0]);

        // Random frames scored against the frame-level model
        for (int f = 0; f < 40; f++) begin
            mode = $urandom_range(0, 9);
            len  = $urandom_range(0, 3);
            if (mode == 0)      a = 16'h1000 | 16'($urandom_range(0, 255));
            else if (mode <= 2) a = 16'(2560 - $urandom_range(0, 4));
            else                a = 16'($urandom_range(0, 2559));
            bad = ($urandom_range(0, 4) == 0);

            pay_q.delete();
            repeat (len * 4) pay_q.push_back(8'($urandom));
            sum = 0;
            foreach (pay_q[i]) sum = (sum + pay_q[i]) % 256;
            csum = bad ? (sum + 1 + int'($urandom_range(0, 254))) % 256 : sum;
            hdr_err = (a >= 16'h1000) || (int'(a) + len > 2560);

            tx_q.delete();
            exp_q.delete();
            repeat ($urandom_range(0, 2)) begin
                nb = 8'($urandom);
                if (nb == 8'hA5) nb = 8'h00;
                tx_q.push_back(nb);
            end
            tx_q.push_back(8'hA5);
            tx_q.push_back(a[15:8]);
            tx_q.push_back(a[7:0]);
            tx_q.push_back(8'h00);
            tx_q.push_back(8'(len));
            if (!hdr_err) begin
                foreach (pay_q[i]) tx_q.push_back(pay_q[i]);
                tx_q.push_back(8'(csum));
                for (int w = 0; w < len; w++)
                    exp_q.push_back({12'(int'(a) + w),
                                     pay_q[4*w+3], pay_q[4*w+2], pay_q[4*w+1], pay_q[4*w]});
            end

            begin_frame();
            send_frame(2, stalls);
            check_result($sformatf("rnd%0d", f), !hdr_err && !bad, hdr_err || bad);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
